// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the CC_PLL reset/lock sequencer: state encodings and helpers.
package pll_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_STDY_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input; clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= {s[STAGES-2:0], d};
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// CC_PLL steady-lock reset pulse, lock wait with retry, settle timer and run-time lock monitor.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pll_locked,
  input  logic                           pll_locked_stdy,
  output logic                           pll_stdy_rst,
  output logic                           sys_rst,
  output logic                           ready,
  output logic                           fault,
  output logic                           relock,
  output logic [STATE_W-1:0]             state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int RW    = $clog2(MAX_RETRY + 1);
  localparam int CNT_W = $clog2(max3(RST_PULSE, SETTLE_CYCLES, LOCK_TIMEOUT) + 1);

  // Terminal values: a phase ends on the edge where its counter already holds N-1.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRY);

  logic lk, st;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lk (
    .clk (clk), .rst (rst), .d (pll_locked),      .q (lk)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_st (
    .clk (clk), .rst (rst), .d (pll_locked_stdy), .q (st)
  );

  // One shared counter: each phase clears it on entry, so it times whichever phase is active.
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d, retry_inc;
  logic               relock_d;

  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    relock_d = 1'b0;
    case (state_q)
      ST_STDY_RST: begin
        if (cnt_q >= PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring on the same edge.
        if (lk) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_STDY_RST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!st) begin
          state_d  = ST_STDY_RST;
          cnt_d    = '0;
          retry_d  = '0;
          relock_d = 1'b1;
        end
      end
      ST_FAULT: ;
      default: begin
        state_d = ST_STDY_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STDY_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_stdy_rst <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      relock       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_stdy_rst <= (state_d == ST_STDY_RST);
      sys_rst      <= (state_d != ST_RUN);
      ready        <= (state_d == ST_RUN);
      fault        <= (state_d == ST_FAULT);
      relock       <= relock_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with default parameters: vector table plus corner-case sequences.
module tb_pll_rst_seq;
  import pll_rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_locked_stdy = 1'b0;
  logic       pll_stdy_rst, sys_rst, ready, fault, relock;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int nchk = 0;
  int nerr = 0;
  int ec   = 0;   // edges since rst was released

  pll_rst_seq dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .pll_locked_stdy (pll_locked_stdy),
    .pll_stdy_rst    (pll_stdy_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .fault           (fault),
    .relock          (relock),
    .state           (state),
    .retry_cnt       (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       pl, ps;   // inputs driven after this edge is checked
    logic [2:0] st;
    logic       sr, sy, rd, rl;
    logic [1:0] rc;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    ec++;
    #1;
  endtask

  task automatic tick_to(input int target);
    while (ec < target) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ec);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic sr, input logic sy,
                         input logic rd, input logic ft, input logic rl, input logic [1:0] rc);
    chk({tag, ".state"},        32'(state),        32'(st));
    chk({tag, ".pll_stdy_rst"}, 32'(pll_stdy_rst), 32'(sr));
    chk({tag, ".sys_rst"},      32'(sys_rst),      32'(sy));
    chk({tag, ".ready"},        32'(ready),        32'(rd));
    chk({tag, ".fault"},        32'(fault),        32'(ft));
    chk({tag, ".relock"},       32'(relock),       32'(rl));
    chk({tag, ".retry_cnt"},    32'(retry_cnt),    32'(rc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_out(tag, ST_STDY_RST, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Hold rst for a few edges, check reset values, then release; next edge is edge 1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals(tag);
    rst = 1'b0;
    ec  = 0;
  endtask

  vec_t tbl[$];

  initial begin
    // Clean lock, then steady-lock loss in RUN and re-lock.
    tbl.push_back('{1,  1'b1, 1'b1, ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{3,  1'b1, 1'b1, ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{4,  1'b1, 1'b1, ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{5,  1'b1, 1'b1, ST_SETTLE,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{20, 1'b1, 1'b1, ST_SETTLE,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{21, 1'b1, 1'b1, ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    tbl.push_back('{25, 1'b1, 1'b0, ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    tbl.push_back('{26, 1'b1, 1'b0, ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    tbl.push_back('{27, 1'b1, 1'b0, ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
    tbl.push_back('{28, 1'b1, 1'b1, ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b1, 2'd0});
    tbl.push_back('{29, 1'b1, 1'b1, ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{31, 1'b1, 1'b1, ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{32, 1'b1, 1'b1, ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{33, 1'b1, 1'b1, ST_SETTLE,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{48, 1'b1, 1'b1, ST_SETTLE,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    tbl.push_back('{49, 1'b1, 1'b1, ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

    // Clean lock and lock loss
    pll_locked = 1'b1; pll_locked_stdy = 1'b1;
    do_reset("reset");
    foreach (tbl[i]) begin
      tick_to(tbl[i].e);
      chk_out($sformatf("vec%0d_e%0d", i, tbl[i].e), tbl[i].st, tbl[i].sr, tbl[i].sy,
              tbl[i].rd, 1'b0, tbl[i].rl, tbl[i].rc);
      pll_locked      = tbl[i].pl;
      pll_locked_stdy = tbl[i].ps;
    end

    // Settle glitch: one-cycle drop of pll_locked at settle count 10
    pll_locked = 1'b1; pll_locked_stdy = 1'b1;
    do_reset("glitch_rst");
    tick_to(15);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick_to(17);
    chk("glitch.e17_state", 32'(state), 32'(ST_SETTLE));
    tick();
    chk("glitch.e18_state", 32'(state), 32'(ST_WAIT_LOCK));
    chk("glitch.e18_retry", 32'(retry_cnt), 32'd0);
    tick();
    chk("glitch.e19_state", 32'(state), 32'(ST_SETTLE));
    tick_to(34);
    chk_out("glitch.e34", ST_SETTLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_out("glitch.e35", ST_RUN,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // Timeout and retry
    pll_locked = 1'b0; pll_locked_stdy = 1'b1;
    do_reset("retry_rst");
    tick_to(1027);
    chk_out("retry.e1027", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_out("retry.e1028", ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick_to(1030);
    pll_locked = 1'b1;
    tick();
    chk("retry.e1031_stdy", 32'(pll_stdy_rst), 32'd1);
    tick();
    chk_out("retry.e1032", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    chk("retry.e1033_state", 32'(state), 32'(ST_SETTLE));
    tick_to(1048);
    chk("retry.e1048_ready", 32'(ready), 32'd0);
    tick();
    chk_out("retry.e1049", ST_RUN,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

    // Fault after three timeouts, sticky until rst
    pll_locked = 1'b0; pll_locked_stdy = 1'b1;
    do_reset("fault_rst");
    tick_to(2055);
    chk("fault.e2055_retry", 32'(retry_cnt), 32'd1);
    tick();
    chk_out("fault.e2056", ST_STDY_RST,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick_to(3083);
    chk_out("fault.e3083", ST_WAIT_LOCK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick();
    chk_out("fault.e3084", ST_FAULT,     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    pll_locked = 1'b1;
    tick_to(3150);
    chk_out("fault.sticky", ST_FAULT,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);

    // One-cycle rst in FAULT, then normal bring-up
    rst = 1'b1;
    tick();
    chk_reset_vals("fault.midrst");
    rst = 1'b0; ec = 0;
    tick_to(4);
    chk("fault_resume.e4_stdy", 32'(pll_stdy_rst), 32'd0);
    tick_to(20);
    chk("fault_resume.e20_ready", 32'(ready), 32'd0);
    tick();
    chk_out("fault_resume.e21", ST_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // One-cycle rst in SETTLE, then normal bring-up
    pll_locked = 1'b1; pll_locked_stdy = 1'b1;
    do_reset("settle_rst");
    tick_to(10);
    chk("settle.e10_state", 32'(state), 32'(ST_SETTLE));
    rst = 1'b1;
    tick();
    chk_reset_vals("settle.midrst");
    rst = 1'b0; ec = 0;
    tick_to(20);
    chk_out("settle_resume.e20", ST_SETTLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_out("settle_resume.e21", ST_RUN,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset and lock sequencer for the CC_PLL clocking resource. It pulses the PLL's steady-lock reset (USR_LOCKED_STDY_RST) and waits for lock, retrying on timeout. It holds user logic (e.g. `blink`) in reset until lock has been stable for a programmable settle time, then monitors steady lock and re-sequences on loss. It runs in the free-running reference clock domain, between the CC_PLL instance and all PLL-clocked user logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for the async PLL lock inputs (≥2).
- `RST_PULSE`, 4: cycles `pll_stdy_rst` is held high per sequence (≥ `SYNC_STAGES`).
- `SETTLE_CYCLES`, 16: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT`, 1024: cycles allowed in WAIT_LOCK before a retry.
- `MAX_RETRY`, 3: timeouts tolerated before FAULT (≥1).
- `clk` in 1: free-running reference clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: CC_PLL USR_PLL_LOCKED, asynchronous to `clk`.
- `pll_locked_stdy` in 1: CC_PLL USR_PLL_LOCKED_STDY, asynchronous to `clk`.
- `pll_stdy_rst` out 1: drives CC_PLL USR_LOCKED_STDY_RST.
- `sys_rst` out 1: synchronous active-high reset for user logic.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `relock` out 1: one-cycle pulse on loss of steady lock in RUN.
- `state` out 3: current state encoding.
- `retry_cnt` out $clog2(MAX_RETRY+1): timeouts in the current bring-up.

## Operation
- States: STDY_RST=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4. Encodings 5–7 are illegal and recover to STDY_RST on the next edge.
- The synchronized inputs are `lk` (from `pll_locked`) and `st` (from `pll_locked_stdy`). Synchronizer flops reset to 0.
- **STDY_RST**:
  - `pll_stdy_rst`=1, `sys_rst`=1.
  - Counts `RST_PULSE` cycles, then goes to WAIT_LOCK. The timeout counter is cleared on entry.
- **WAIT_LOCK**:
  - `pll_stdy_rst`=0, `sys_rst`=1.
  - `lk`=1 → SETTLE with the settle counter = 0.
  - Otherwise, the timeout counter increments. When it reaches `LOCK_TIMEOUT`, `retry_cnt` increments. Then go to FAULT if the new value equals `MAX_RETRY`, else go to STDY_RST.
- **SETTLE**:
  - `sys_rst`=1.
  - `lk`=0 → WAIT_LOCK with the timeout counter restarted at 0. `retry_cnt` is unchanged.
  - After `SETTLE_CYCLES` consecutive `lk`=1 cycles → RUN.
- **RUN**:
  - `sys_rst`=0, `ready`=1.
  - `st`=0 → STDY_RST. On that edge: `relock` pulses for 1 cycle, `sys_rst`→1, `ready`→0, `retry_cnt`→0.
  - `lk` alone is ignored in RUN.
- **FAULT**:
  - `sys_rst`=1, `pll_stdy_rst`=0, `fault`=1.
  - Sticky until `rst`.
- Simultaneous events:
  - In WAIT_LOCK, `lk` rising in the same cycle as timeout expiry: lock wins, go to SETTLE, no retry counted.
  - `rst` overrides everything, in any state.
- Counters saturate. They never wrap.

## Timing
- All outputs are registered.
- Values during/after `rst`: state=STDY_RST, `pll_stdy_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `relock`=0, `retry_cnt`=0, all counters 0.
- Input latency: `SYNC_STAGES` cycles from a lock input change to `lk`/`st`.
- Release with the PLL already locked: the first edge with `rst`=0 is cycle 1.
  - `pll_stdy_rst` falls at edge `RST_PULSE`.
  - SETTLE is entered at edge `RST_PULSE`+1.
  - `sys_rst` falls and `ready` rises at edge `RST_PULSE`+1+`SETTLE_CYCLES`. With defaults this is edge 21.
- Lock loss in RUN: `sys_rst` rises `SYNC_STAGES`+1 edges after `pll_locked_stdy` falls.
- `rst` asserted mid-operation: reset values appear on the next edge.

## Structure
- Shared package/include `pll_rst_seq_pkg` holds the state encoding constants and the 3-bit state width. The package is shared with the testbench for state checks.
- The synchronizer is one sub-module, `sync_ff`, parameterized by `STAGES` with a synchronous reset. It is instantiated once per lock input.
- The FSM and counters live in `pll_rst_seq`. The CC_PLL model is not modified.

## Test plan
All scenarios use default parameters.
- **Clean lock:** both lock inputs held 1 from reset; release `rst` → `pll_stdy_rst` high edges 1–4; `sys_rst` 0 and `ready` 1 at edge 21; `retry_cnt`=0.
- **Settle glitch:** `pll_locked` drops for 1 cycle at SETTLE count 10 → returns to WAIT_LOCK; a full 16-cycle settle restarts; no retry counted.
- **Timeout/retry:** `pll_locked`=0 for 1030 cycles after the first STDY_RST, then 1 → `retry_cnt`=1; second STDY_RST pulse of 4 cycles; RUN reached afterwards.
- **Fault:** `pll_locked` held 0 → FAULT after 3 timeouts (3 × (4+1024) cycles plus transition edges, checked via `state`=4); `fault`=1 and `sys_rst`=1 held until `rst`.
- **Lock loss in RUN:** drop `pll_locked_stdy` → `relock` 1-cycle pulse; `sys_rst`=1 at loss+3 edges; `pll_stdy_rst` pulses 4 cycles; `retry_cnt`=0; RUN re-entered when the lock inputs return to 1.
- **Mid-sequence reset:** assert `rst` for 1 cycle during SETTLE and during FAULT → all outputs at reset values next edge; normal sequence resumes.
